pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 161 ++++++++++++++++
 tb/tb_pipeline_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: stall/flush/enable generation, operand forwarding
// and data-memory wait/timeout tracking for a 5-stage in-order pipeline.
// Optional feature macro: PIPELINE_CONTROLLER_FORWARD_EN (E-stage forwarding;
// when undefined, forwarding is tied off and RAW hazards on E/M stall instead).
module pipeline_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic [4:0]  rs1_addrD,
  input  logic [4:0]  rs2_addrD,
  input  logic        rs1_useD,
  input  logic        rs2_useD,
  input  logic [4:0]  rd_addrE,
  input  logic        rd_wrenE,
  input  logic        ld_E,
  input  logic [4:0]  rs1_addrE,
  input  logic [4:0]  rs2_addrE,
  input  logic [4:0]  rd_addrM,
  input  logic        rd_wrenM,
  input  logic        mem_reqM,
  input  logic        mem_ackM,
  input  logic [4:0]  rd_addrW,
  input  logic        rd_wrenW,
  input  logic        br_takenE,
  output logic        en_pc,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        clr_fd,
  output logic        clr_de,
  output logic [1:0]  fwd_aE,
  output logic [1:0]  fwd_bE,
  output logic        mem_busy,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam int unsigned CW = 8;
  localparam int unsigned SW = 16;

  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, ERR = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          mem_err_nxt;
  logic          br_pend, br_pend_nxt;
  logic [SW-1:0] stall_cnt_nxt;
  logic          freeze;
  logic          branch;
  logic          raw_stall;
  logic          rs1_hit_e, rs2_hit_e;

  // Decode sources that depend on the instruction currently in execute.
  assign rs1_hit_e = rd_wrenE && (rd_addrE != 5'd0) && rs1_useD && (rs1_addrD == rd_addrE);
  assign rs2_hit_e = rd_wrenE && (rd_addrE != 5'd0) && rs2_useD && (rs2_addrD == rd_addrE);

`ifdef PIPELINE_CONTROLLER_FORWARD_EN
  // Only a load in execute cannot be forwarded in time.
  assign raw_stall = ld_E && (rs1_hit_e || rs2_hit_e);

  // Memory stage holds the youngest value, so it wins over writeback.
  assign fwd_aE = (rd_wrenM && (rd_addrM != 5'd0) && (rd_addrM == rs1_addrE)) ? 2'b01 :
                  (rd_wrenW && (rd_addrW != 5'd0) && (rd_addrW == rs1_addrE)) ? 2'b10 : 2'b00;
  assign fwd_bE = (rd_wrenM && (rd_addrM != 5'd0) && (rd_addrM == rs2_addrE)) ? 2'b01 :
                  (rd_wrenW && (rd_addrW != 5'd0) && (rd_addrW == rs2_addrE)) ? 2'b10 : 2'b00;
`else
  logic rs1_hit_m, rs2_hit_m;
  logic unused_fwd_inputs;

  // Without bypassing, any in-flight E/M producer must drain first; W is covered by write-through.
  assign rs1_hit_m = rd_wrenM && (rd_addrM != 5'd0) && rs1_useD && (rs1_addrD == rd_addrM);
  assign rs2_hit_m = rd_wrenM && (rd_addrM != 5'd0) && rs2_useD && (rs2_addrD == rd_addrM);
  assign raw_stall = rs1_hit_e || rs2_hit_e || rs1_hit_m || rs2_hit_m;

  assign fwd_aE = 2'b00;
  assign fwd_bE = 2'b00;
  assign unused_fwd_inputs = ^{ld_E, rs1_addrE, rs2_addrE, rd_addrW, rd_wrenW};
`endif

  // State, wait counter, error flag, held branch and stall counter.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      br_pend   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err   <= mem_err_nxt;
      br_pend   <= br_pend_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // Next-state logic and priority-resolved enables: freeze > branch > stall > run.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    mem_err_nxt   = mem_err;
    br_pend_nxt   = br_pend;
    stall_cnt_nxt = stall_cnt;
    en_pc         = 1'b1;
    en_fd         = 1'b1;
    en_de         = 1'b1;
    en_em         = 1'b1;
    en_mw         = 1'b1;
    clr_fd        = 1'b0;
    clr_de        = 1'b0;

    freeze   = (mem_reqM && !mem_ackM) || (state == ERR);
    branch   = !freeze && (br_takenE || br_pend);
    mem_busy = (state == WAIT) || freeze;

    case (state)
      RUN: begin
        if (mem_reqM && !mem_ackM) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_ackM) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
          state_nxt    = ERR;
          mem_err_nxt  = 1'b1;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: state_nxt = RUN;
    endcase

    if (freeze) begin
      en_pc = 1'b0;
      en_fd = 1'b0;
      en_de = 1'b0;
      en_em = 1'b0;
      en_mw = 1'b0;
    end else if (branch) begin
      clr_fd = 1'b1;
      clr_de = 1'b1;
    end else if (raw_stall) begin
      en_pc  = 1'b0;
      en_fd  = 1'b0;
      clr_de = 1'b1;
    end

    // A branch seen while frozen is remembered until the pipeline can move.
    br_pend_nxt = freeze ? (br_pend || br_takenE) : 1'b0;

    if (!en_fd && (stall_cnt != {SW{1'b1}})) stall_cnt_nxt = stall_cnt + SW'(1);
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: directed scenarios then random traffic,
// each cycle's expectation computed by a behavioural model and queued for a negedge monitor.
module tb_pipeline_controller;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        aclr;
  logic [4:0]  rs1_addrD, rs2_addrD, rd_addrE, rs1_addrE, rs2_addrE, rd_addrM, rd_addrW;
  logic        rs1_useD, rs2_useD, rd_wrenE, ld_E, rd_wrenM, mem_reqM, mem_ackM, rd_wrenW, br_takenE;
  logic        en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, mem_busy, mem_err;
  logic [1:0]  fwd_aE, fwd_bE;
  logic [15:0] stall_cnt;

  pipeline_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .aclr(aclr),
    .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD), .rs1_useD(rs1_useD), .rs2_useD(rs2_useD),
    .rd_addrE(rd_addrE), .rd_wrenE(rd_wrenE), .ld_E(ld_E),
    .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE),
    .rd_addrM(rd_addrM), .rd_wrenM(rd_wrenM), .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
    .rd_addrW(rd_addrW), .rd_wrenW(rd_wrenW), .br_takenE(br_takenE),
    .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .clr_fd(clr_fd), .clr_de(clr_de), .fwd_aE(fwd_aE), .fwd_bE(fwd_bE),
    .mem_busy(mem_busy), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1D; logic [4:0] rs2D; logic u1; logic u2;
    logic [4:0] rdE; logic wrE; logic ldE; logic [4:0] rs1E; logic [4:0] rs2E;
    logic [4:0] rdM; logic wrM; logic req; logic ack;
    logic [4:0] rdW; logic wrW; logic br;
  } stim_t;

  logic [28:0] exp_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Behavioural model state: what the memory interface is doing, and counters.
  bit m_wait, m_err, m_br_held;
  int m_waited, m_stalls;

  function automatic bit d_reads(input stim_t s, input logic [4:0] r);
    return (r != 5'd0) && ((s.u1 && s.rs1D == r) || (s.u2 && s.rs2D == r));
  endfunction

  function automatic logic [1:0] src_sel(input stim_t s, input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (s.wrM && s.rdM == src) return 2'b01;
    if (s.wrW && s.rdW == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit frozen(input stim_t s);
    return m_err || (s.req && !s.ack);
  endfunction

  function automatic logic [28:0] predict(input stim_t s);
    bit fz, flush, raw;
    logic [4:0] en;
    logic [1:0] clr, fa, fb;
    fz    = frozen(s);
    flush = !fz && (s.br || m_br_held);
`ifdef PIPELINE_CONTROLLER_FORWARD_EN
    raw = s.ldE && s.wrE && d_reads(s, s.rdE);
    fa  = src_sel(s, s.rs1E);
    fb  = src_sel(s, s.rs2E);
`else
    raw = (s.wrE && d_reads(s, s.rdE)) || (s.wrM && d_reads(s, s.rdM));
    fa  = 2'b00;
    fb  = 2'b00;
`endif
    if (fz)         begin en = 5'b00000; clr = 2'b00; end
    else if (flush) begin en = 5'b11111; clr = 2'b11; end
    else if (raw)   begin en = 5'b00111; clr = 2'b01; end
    else            begin en = 5'b11111; clr = 2'b00; end
    return {en, clr, fa, fb, (m_wait || fz), m_err, 16'(m_stalls)};
  endfunction

  task automatic advance(input stim_t s, input logic fd_enabled);
    bit fz;
    fz = frozen(s);
    m_br_held = fz ? (m_br_held || s.br) : 1'b0;
    if (!fd_enabled && m_stalls < 65535) m_stalls++;
    if (m_err) begin
    end else if (m_wait) begin
      if (s.ack) begin
        m_wait = 0; m_waited = 0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin m_err = 1; m_wait = 0; m_waited = 0; end
      end
    end else if (s.req && !s.ack) begin
      m_wait = 1;
    end
  endtask

  task automatic apply(input stim_t s);
    rs1_addrD = s.rs1D; rs2_addrD = s.rs2D; rs1_useD = s.u1; rs2_useD = s.u2;
    rd_addrE = s.rdE; rd_wrenE = s.wrE; ld_E = s.ldE; rs1_addrE = s.rs1E; rs2_addrE = s.rs2E;
    rd_addrM = s.rdM; rd_wrenM = s.wrM; mem_reqM = s.req; mem_ackM = s.ack;
    rd_addrW = s.rdW; rd_wrenW = s.wrW; br_takenE = s.br;
  endtask

  task automatic cyc(input stim_t s, input string tag);
    logic [28:0] e;
    @(posedge clk); #1;
    apply(s);
    e = predict(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    advance(s, e[27]);
  endtask

  task automatic pulse_reset(input string tag);
    stim_t z;
    z = '0;
    @(posedge clk); #1;
    apply(z);
    aclr = 1'b1;
    m_wait = 0; m_err = 0; m_br_held = 0; m_waited = 0; m_stalls = 0;
    exp_q.push_back(predict(z));
    tag_q.push_back(tag);
    @(posedge clk); #1;
    aclr = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the DUT away from the clock edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [28:0] e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, fwd_aE, fwd_bE, mem_busy, mem_err, stall_cnt};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got en=%b clr=%b fa=%b fb=%b busy=%b err=%b cnt=%0d, expected en=%b clr=%b fa=%b fb=%b busy=%b err=%b cnt=%0d",
                 t, a[28:24], a[23:22], a[21:20], a[19:18], a[17], a[16], a[15:0],
                 e[28:24], e[23:22], e[21:20], e[19:18], e[17], e[16], e[15:0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    s = '0;
    aclr = 1'b1;
    apply(s);
    pulse_reset("reset_state");

    // Load-use on x5 stalls exactly once, then the counter shows it.
    s = '0; s.ldE = 1; s.wrE = 1; s.rdE = 5'd5; s.u1 = 1; s.rs1D = 5'd5;
    cyc(s, "load_use");
    s = '0; cyc(s, "load_use_after");
    s = '0; s.ldE = 1; s.wrE = 1; s.rdE = 5'd0; s.u1 = 1; s.rs1D = 5'd0;
    cyc(s, "load_use_x0");

    // Forward priority on rs2.
    s = '0; s.wrM = 1; s.rdM = 5'd7; s.wrW = 1; s.rdW = 5'd7; s.rs2E = 5'd7; s.rs1E = 5'd7;
    cyc(s, "fwd_m_prio");
    s.wrM = 0; cyc(s, "fwd_w");
    s.rs2E = 5'd0; s.rs1E = 5'd0; cyc(s, "fwd_x0");

    // Memory wait: two frozen cycles then the ack cycle advances.
    s = '0; s.req = 1; cyc(s, "memwait_1");
    cyc(s, "memwait_2");
    s.ack = 1; cyc(s, "mem_ack");
    s = '0; cyc(s, "after_ack");

    // Branch beats load-use in the same cycle.
    s = '0; s.br = 1; s.ldE = 1; s.wrE = 1; s.rdE = 5'd5; s.u1 = 1; s.rs1D = 5'd5;
    cyc(s, "br_over_lu");

    // Branch pulse during freeze is held and applied when the pipeline next moves.
    s = '0; s.req = 1; s.br = 1; cyc(s, "br_frozen");
    s.br = 0; cyc(s, "br_held");
    s.ack = 1; cyc(s, "br_ack_apply");
    s = '0; cyc(s, "br_after");

    // ALU dependency through the memory stage.
    s = '0; s.u1 = 1; s.rs1D = 5'd3; s.wrM = 1; s.rdM = 5'd3; s.rs1E = 5'd3;
    cyc(s, "alu_dep_m");
    s = '0; cyc(s, "alu_dep_after");

    // Reset in the middle of a wait.
    s = '0; s.req = 1; cyc(s, "pre_rst_wait_1");
    cyc(s, "pre_rst_wait_2");
    pulse_reset("reset_in_wait");
    s = '0; s.req = 1; s.ack = 1; cyc(s, "run_after_reset");

    // Timeout into the sticky error state.
    s = '0; s.req = 1;
    for (int i = 0; i < 6; i++) cyc(s, "timeout_wait");
    s = '0; s.br = 1; cyc(s, "err_sticky_1");
    s = '0; cyc(s, "err_sticky_2");
    pulse_reset("reset_from_err");
    s = '0; cyc(s, "after_err_reset");

    // Randomised traffic with small register indices so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        pulse_reset("rand_reset");
      end else begin
        s.rs1D = 5'($urandom_range(0, 3)); s.rs2D = 5'($urandom_range(0, 3));
        s.u1   = 1'($urandom_range(0, 1)); s.u2   = 1'($urandom_range(0, 1));
        s.rdE  = 5'($urandom_range(0, 3)); s.wrE  = 1'($urandom_range(0, 1));
        s.ldE  = 1'($urandom_range(0, 1));
        s.rs1E = 5'($urandom_range(0, 3)); s.rs2E = 5'($urandom_range(0, 3));
        s.rdM  = 5'($urandom_range(0, 3)); s.wrM  = 1'($urandom_range(0, 1));
        s.rdW  = 5'($urandom_range(0, 3)); s.wrW  = 1'($urandom_range(0, 1));
        s.req  = ($urandom_range(0, 4) == 0);
        s.ack  = ($urandom_range(0, 2) == 0);
        s.br   = ($urandom_range(0, 9) == 0);
        cyc(s, "random");
      end
    end

    @(negedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
